mr_rd_sched: RTL and testbench

- Schedules the single shared memory read port between the MR stage (operand / indirect-target reads) and instruction fetch.
- Splits unaligned 32-bit MR reads into two aligned word accesses and merges the result.
- Returns mem_val and read_finished to the MR stage and if_data/if_ack to fetch.
- MR has fixed priority, bounded by an anti-starvation counter for fetch.

---
 rtl/mr_rd_sched_if.sv | 30 +++
 rtl/mr_rd_sched.sv | 144 ++++++++++++++
 tb/tb_mr_rd_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mr_rd_sched_if.sv
// mr_rd_sched_if
// Groups the MR-stage request/response, fetch request/response and the
// shared memory read bus used by mr_rd_sched.
//   master : scheduler side (drives mem_rd_*, read_finished/mem_val,
//            if_ack/if_data; receives requests and bus responses)
//   slave  : environment side (MR stage, fetch unit and memory)
interface mr_rd_sched_if;
  logic        mr_req;
  logic [31:0] mr_addr;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic [31:0] mem_rd_data;
  logic        read_finished;
  logic [31:0] mem_val;
  logic        if_ack;
  logic [31:0] if_data;

  modport master (
    input  mr_req, mr_addr, if_req, if_addr, mem_rd_ack, mem_rd_data,
    output mem_rd_req, mem_rd_addr, read_finished, mem_val, if_ack, if_data
  );

  modport slave (
    output mr_req, mr_addr, if_req, if_addr, mem_rd_ack, mem_rd_data,
    input  mem_rd_req, mem_rd_addr, read_finished, mem_val, if_ack, if_data
  );
endinterface

// File: rtl/mr_rd_sched.sv
// mr_rd_sched
// Arbitrates the single shared memory read port between the MR stage
// (operand / indirect-target reads) and instruction fetch. Unaligned MR
// reads are split into two aligned word accesses and merged
// little-endian. MR has fixed priority, bounded by a starvation counter
// that forces a fetch grant after STARVE_MAX consecutive MR grants.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mr_rd_sched_if.master (MR/fetch requests and results, memory bus)
module mr_rd_sched #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mr_rd_sched_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE, MR_LO, MR_HI, IF_RD, MR_DONE, IF_DONE
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t      state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        rf_q;
  logic [31:0] val_q;
  logic        ifack_q;
  logic [31:0] ifdata_q;
  logic [3:0]  starve_q;
  logic [31:0] lo_q;
  logic [1:0]  off_q;
  logic        ack_v;

  // Little-endian merge of two consecutive words starting at byte offset off.
  function automatic logic [31:0] merge_words(input logic [31:0] hi,
                                              input logic [31:0] lo,
                                              input logic [1:0]  off);
    logic [63:0] cat;
    cat = {hi, lo} >> {off, 3'b000};
    return cat[31:0];
  endfunction

  // An ack only counts while a request is actually on the bus; this also
  // drops stray acks that arrive after a reset.
  assign ack_v = bus.mem_rd_ack && req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= 32'd0;
      rf_q     <= 1'b0;
      val_q    <= 32'd0;
      ifack_q  <= 1'b0;
      ifdata_q <= 32'd0;
      starve_q <= 4'd0;
      lo_q     <= 32'd0;
      off_q    <= 2'd0;
    end else begin
      rf_q    <= 1'b0;
      ifack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.if_req) starve_q <= 4'd0;
          // The word address is loaded at grant; the request itself goes
          // out one cycle later from the access state.
          if (bus.if_req && (starve_q == SMAX || !bus.mr_req)) begin
            state_q  <= IF_RD;
            addr_q   <= bus.if_addr & 32'hFFFF_FFFC;
            starve_q <= 4'd0;
          end else if (bus.mr_req) begin
            state_q <= MR_LO;
            addr_q  <= {bus.mr_addr[31:2], 2'b00};
            off_q   <= bus.mr_addr[1:0];
            if (bus.if_req && starve_q != SMAX) starve_q <= starve_q + 4'd1;
          end
        end
        MR_LO: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (ack_v) begin
            if (off_q == 2'd0) begin
              req_q <= 1'b0;
              if (bus.mr_req) begin
                val_q   <= bus.mem_rd_data;
                rf_q    <= 1'b1;
                state_q <= MR_DONE;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              // Second word follows back-to-back; address wraps at 2^32.
              lo_q    <= bus.mem_rd_data;
              addr_q  <= addr_q + 32'd4;
              state_q <= MR_HI;
            end
          end
        end
        MR_HI: begin
          if (ack_v) begin
            req_q <= 1'b0;
            if (bus.mr_req) begin
              val_q   <= merge_words(bus.mem_rd_data, lo_q, off_q);
              rf_q    <= 1'b1;
              state_q <= MR_DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        IF_RD: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (ack_v) begin
            req_q <= 1'b0;
            if (bus.if_req) begin
              ifdata_q <= bus.mem_rd_data;
              ifack_q  <= 1'b1;
              state_q  <= IF_DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        // Done states never grant, so the still-high request of the
        // requester that just completed is not re-issued.
        MR_DONE: state_q <= IDLE;
        IF_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_req    = req_q;
  assign bus.mem_rd_addr   = addr_q;
  assign bus.read_finished = rf_q;
  assign bus.mem_val       = val_q;
  assign bus.if_ack        = ifack_q;
  assign bus.if_data       = ifdata_q;

endmodule

// File: tb/tb_mr_rd_sched.sv
module tb_mr_rd_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mr_rd_sched_if vif ();

  mr_rd_sched #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] rsp[64];
  logic [31:0] acc_addr[64];
  int   acc_n = 0;
  int   ack_dly = 0;
  int   ack_limit = 64;
  int   wait_cnt = 0;
  logic force_ack = 1'b0;

  int rf_cnt = 0;
  int ifa_cnt = 0;
  int ev[64];
  int ev_n = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] exp_val;
    logic [31:0] a0;
    logic [31:0] a1;
    int          dly;
    int          n;
    int          lat;
  } vec_t;

  vec_t tv[5];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers accesses in order from rsp[], logs addresses.
  always @(negedge clk) begin
    if (force_ack) begin
      vif.mem_rd_ack  = 1'b1;
      vif.mem_rd_data = 32'hBAD0_BAD0;
    end else if (vif.mem_rd_req && acc_n < ack_limit && acc_n < 64) begin
      if (wait_cnt == ack_dly) begin
        vif.mem_rd_ack  = 1'b1;
        vif.mem_rd_data = rsp[acc_n];
        acc_addr[acc_n] = vif.mem_rd_addr;
        acc_n = acc_n + 1;
        wait_cnt = 0;
      end else begin
        vif.mem_rd_ack = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      vif.mem_rd_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Completion monitor: 0 = MR completion, 1 = fetch completion.
  always @(negedge clk) begin
    if (vif.read_finished) begin
      rf_cnt = rf_cnt + 1;
      if (ev_n < 64) begin ev[ev_n] = 0; ev_n = ev_n + 1; end
    end
    if (vif.if_ack) begin
      ifa_cnt = ifa_cnt + 1;
      if (ev_n < 64) begin ev[ev_n] = 1; ev_n = ev_n + 1; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_mr(input vec_t v, input string tag);
    int base, rfb, c0, lat;
    bit got;
    @(negedge clk);
    base = acc_n;
    rfb  = rf_cnt;
    rsp[base]     = v.lo;
    rsp[base + 1] = v.hi;
    ack_dly = v.dly;
    vif.mr_addr = v.addr;
    vif.mr_req  = 1'b1;
    c0  = cyc;
    got = 0;
    lat = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (vif.read_finished) begin
        got = 1;
        lat = cyc - c0;
        vif.mr_req = 1'b0;
      end
    end
    vif.mr_req = 1'b0;
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_val"}, vif.mem_val, v.exp_val);
    chk({tag, "_nacc"}, acc_n - base, v.n);
    chk({tag, "_a0"}, acc_addr[base], v.a0);
    if (v.n == 2) chk({tag, "_a1"}, acc_addr[base + 1], v.a1);
    chk({tag, "_pulses"}, rf_cnt - rfb, 32'd1);
  endtask

  initial begin
    int base, rfb, ifb, evb;
    bit got;
    vec_t rv;

    tv[0] = '{32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0, 0, 1, 3};
    tv[1] = '{32'h0000_2002, 32'h3322_1100, 32'h7766_5544, 32'h5544_3322, 32'h0000_2000, 32'h0000_2004, 0, 2, 4};
    tv[2] = '{32'hFFFF_FFFF, 32'hAABB_CCDD, 32'h0011_2233, 32'h1122_33AA, 32'hFFFF_FFFC, 32'h0000_0000, 0, 2, 4};
    tv[3] = '{32'h0000_4001, 32'h3322_1100, 32'h7766_5544, 32'h4433_2211, 32'h0000_4000, 32'h0000_4004, 1, 2, 6};
    tv[4] = '{32'h0000_4003, 32'h3322_1100, 32'h7766_5544, 32'h6655_4433, 32'h0000_4000, 32'h0000_4004, 2, 2, 8};

    vif.mr_req = 1'b0;
    vif.mr_addr = 32'd0;
    vif.if_req = 1'b0;
    vif.if_addr = 32'd0;
    vif.mem_rd_ack = 1'b0;
    vif.mem_rd_data = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, vif.mem_rd_req}, 32'd0);
    chk("rst_addr", vif.mem_rd_addr, 32'd0);
    chk("rst_rf", {31'd0, vif.read_finished}, 32'd0);
    chk("rst_val", vif.mem_val, 32'd0);
    chk("rst_ifack", {31'd0, vif.if_ack}, 32'd0);
    chk("rst_ifdata", vif.if_data, 32'd0);

    for (int k = 0; k < 5; k++) run_mr(tv[k], $sformatf("vec%0d", k));

    // Starvation: both requesters held continuously.
    @(negedge clk);
    base = acc_n;
    evb  = ev_n;
    for (int i = 0; i < 12; i++) rsp[base + i] = 32'h1F00_0000 | i;
    ack_dly = 0;
    vif.mr_addr = 32'h0000_5000;
    vif.if_addr = 32'h0000_8003;
    vif.mr_req = 1'b1;
    vif.if_req = 1'b1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ev_n >= evb + 6) begin
        got = 1;
        vif.mr_req = 1'b0;
        vif.if_req = 1'b0;
      end
    end
    vif.mr_req = 1'b0;
    vif.if_req = 1'b0;
    if (!got) chk("starve_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk("starve_ev0", ev[evb + 0], 32'd0);
    chk("starve_ev1", ev[evb + 1], 32'd0);
    chk("starve_ev2", ev[evb + 2], 32'd0);
    chk("starve_ev3", ev[evb + 3], 32'd0);
    chk("starve_ev4", ev[evb + 4], 32'd1);
    chk("starve_ev5", ev[evb + 5], 32'd0);
    chk("starve_mraddr", acc_addr[base], 32'h0000_5000);
    chk("starve_ifaddr", acc_addr[base + 4], 32'h0000_8000);
    chk("starve_ifdata", vif.if_data, 32'h1F00_0004);
    chk("starve_val", vif.mem_val, 32'h1F00_0005);

    // Flush: MR request withdrawn while its access is outstanding.
    @(negedge clk);
    base = acc_n;
    rfb  = rf_cnt;
    rsp[base]     = 32'h0BAD_F00D;
    rsp[base + 1] = 32'h1234_5678;
    ack_dly = 3;
    vif.mr_addr = 32'h0000_3000;
    vif.if_addr = 32'h0000_9000;
    vif.mr_req = 1'b1;
    vif.if_req = 1'b1;
    repeat (3) @(negedge clk);
    vif.mr_req = 1'b0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (vif.if_ack) begin
        got = 1;
        vif.if_req = 1'b0;
      end
    end
    vif.if_req = 1'b0;
    if (!got) chk("flush_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    ack_dly = 0;
    chk("flush_pulses", rf_cnt - rfb, 32'd0);
    chk("flush_val", vif.mem_val, 32'h1F00_0005);
    chk("flush_nacc", acc_n - base, 32'd2);
    chk("flush_a0", acc_addr[base], 32'h0000_3000);
    chk("flush_a1", acc_addr[base + 1], 32'h0000_9000);
    chk("flush_ifdata", vif.if_data, 32'h1234_5678);

    // Reset in MR_HI with the second ack stalled, then a stray ack.
    @(negedge clk);
    base = acc_n;
    ack_limit = base + 1;
    rsp[base] = 32'h1111_1111;
    vif.mr_addr = 32'h0000_6001;
    vif.mr_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("hi_req", {31'd0, vif.mem_rd_req}, 32'd1);
    chk("hi_addr", vif.mem_rd_addr, 32'h0000_6004);
    chk("hi_nacc", acc_n - base, 32'd1);
    rst = 1'b1;
    vif.mr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rfb = rf_cnt;
    ifb = ifa_cnt;
    chk("mrst_req", {31'd0, vif.mem_rd_req}, 32'd0);
    chk("mrst_addr", vif.mem_rd_addr, 32'd0);
    chk("mrst_rf", {31'd0, vif.read_finished}, 32'd0);
    chk("mrst_val", vif.mem_val, 32'd0);
    chk("mrst_ifack", {31'd0, vif.if_ack}, 32'd0);
    chk("mrst_ifdata", vif.if_data, 32'd0);
    force_ack = 1'b1;
    ack_limit = 64;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_rf", rf_cnt - rfb, 32'd0);
    chk("late_ifack", ifa_cnt - ifb, 32'd0);
    chk("late_val", vif.mem_val, 32'd0);
    chk("late_req", {31'd0, vif.mem_rd_req}, 32'd0);

    rv = '{32'h0000_7000, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'h0000_7000, 32'h0, 0, 1, 3};
    run_mr(rv, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
